fuzzy_rule_scheduler: RTL and testbench
=======================================

FUZZY_RULE_SCHEDULER -- requirements
Module: FuzzyRuleScheduler

Interface
REQ-001 SHALL have parameter `WIDTH`, default 3: bit width of membership and strength values.
REQ-002 SHALL have parameter `MAX_RULES`, default 15: largest rule count per command; the count field is 4 bits.
REQ-003 SHALL have ports:
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `io_cmd_valid`  in  1: evaluation command offered.
- `io_cmd_ready`  out  1: command accepted when high together with `io_cmd_valid`.
- `io_cmd_bits_numRules`  in  4: number of rules to evaluate, 0..15.
- `io_rule_valid`  in  1: rule antecedent set offered.
- `io_rule_ready`  out  1: rule accepted when high together with `io_rule_valid`.
- `io_rule_bits_0`..`io_rule_bits_3`  in  WIDTH each: four membership degrees of one rule.
- `io_cmp_start`  out  1: advance enable to the shared two-stage comparator tree.
- `io_cmp_inputs_0`..`io_cmp_inputs_3`  out  WIDTH each: operands to the tree.
- `io_cmp_result`  in  WIDTH: tree output (firing strength), two enabled cycles after issue.
- `io_out_valid`  out  1: aggregated result available.
- `io_out_ready`  in  1: result consumed when high together with `io_out_valid`.
- `io_out_bits`  out  WIDTH: maximum firing strength over all rules of the command.
- `io_busy`  out  1: high in every state except IDLE.

Function
REQ-004 SHALL implement states IDLE, ISSUE, DRAIN and DONE.
REQ-005 In IDLE: `io_cmd_ready`=1. On cmd fire, SHALL latch numRules, clear `acc`, `issued` and `retired`, then go to ISSUE; if numRules=0 it SHALL go directly to DONE with `acc`=0.
REQ-006 `io_cmp_start` SHALL be 1 in ISSUE and DRAIN and 0 in IDLE and DONE, so the tree is frozen outside an evaluation.
REQ-007 In ISSUE: `io_rule_ready`=1, and `io_cmp_inputs_k` SHALL equal `io_rule_bits_k` combinationally.
REQ-008 A rule fire in ISSUE SHALL increment `issued`; on the fire that makes `issued`=numRules, the next state SHALL be DRAIN.
REQ-009 `io_rule_ready` SHALL be 0 in all states other than ISSUE.
REQ-010 Slot tracking:
- The block SHALL keep a 2-bit tag shift register, advanced only on cycles where `io_cmp_start`=1.
- `tag0` <= rule fire; `tag1` <= `tag0`.
- A cycle with `io_rule_valid`=0 in ISSUE inserts a bubble (tag 0).
REQ-011 When `tag1`=1, `io_cmp_result` SHALL be treated as valid that cycle: `acc` <= max(`acc`, `io_cmp_result`) unsigned, and `retired` increments.
REQ-012 Results with `tag1`=0 SHALL never alter `acc`.
REQ-013 When a retire makes `retired`=numRules (in ISSUE or DRAIN), the next state SHALL be DONE.
REQ-014 Retiring continues during ISSUE, so back-to-back rules are fully pipelined at one rule per cycle.
REQ-015 Latency: for N≥1 rules issued on consecutive cycles t..t+N-1, `io_out_valid` SHALL first be 1 at cycle t+N+2.
REQ-016 In DONE: `io_out_valid`=1 and `io_out_bits`=`acc`, held stable until `io_out_ready`=1; then go to IDLE. `io_cmd_ready` SHALL be 0 in DONE.
REQ-017 `acc` SHALL saturate naturally at 2^WIDTH-1; remaining rules SHALL still be consumed.
REQ-018 `io_out_bits` SHALL equal `acc` in every state; it is meaningful only while `io_out_valid`=1.
REQ-019 On a simultaneous rule fire and retire in the same cycle, both counters SHALL update in that cycle.
REQ-020 `io_cmd_valid` outside IDLE SHALL be ignored, with no effect on state.

Reset
REQ-021 While `reset`=1 at a clock edge, the block SHALL enter IDLE with `acc`, `issued`, `retired`, `tag0` and `tag1` all 0.
REQ-022 Resulting outputs after reset: `io_cmd_ready`=1, `io_rule_ready`=0, `io_cmp_start`=0, `io_out_valid`=0, `io_busy`=0.
REQ-023 Reset asserted mid-ISSUE or mid-DRAIN SHALL abort the evaluation: no `io_out_valid` pulse, and in-flight tags discarded.

Verification
REQ-024 cmd numRules=4, rules (3,5,6,7),(1,2,2,4),(6,6,7,6),(0,7,7,7) back-to-back from cycle t, tree in min mode -> `io_out_valid`=1 at t+6 with `io_out_bits`=6.
REQ-025 cmd numRules=0 -> DONE on the next cycle, `io_out_bits`=0, no rule accepted, `io_cmp_start` never 1.
REQ-026 numRules=3 with `io_rule_valid` low on every other cycle -> bubbles do not change `acc`; `io_out_bits`=max of the 3 strengths; `retired`=3 at DONE.
REQ-027 Hold `io_out_ready`=0 for 5 cycles in DONE -> `io_out_valid` and `io_out_bits` stable; `io_cmd_ready`=0 throughout; IDLE entered the cycle after `io_out_ready`=1.
REQ-028 Assert `reset` one cycle after the 2nd of 4 rules issues -> next cycle in IDLE, `io_busy`=0; a fresh numRules=1 command with rule (7,7,7,7) yields `io_out_bits`=7.
REQ-029 numRules=15, all rules (7,7,7,7) -> `io_out_bits`=7 (saturation) and exactly 15 rule fires.

Source files
------------

// File: rtl/fuzzy_rule_scheduler.sv
// Fuzzy rule scheduler: streams rule antecedent sets into a shared two-stage
// comparator tree, tracks in-flight slots with a tag pipeline, and aggregates
// the maximum firing strength over all rules of one command.
module fuzzy_rule_scheduler #(
  parameter int WIDTH     = 3,
  parameter int MAX_RULES = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_cmd_valid,
  output logic             io_cmd_ready,
  input  logic [3:0]       io_cmd_bits_numRules,
  input  logic             io_rule_valid,
  output logic             io_rule_ready,
  input  logic [WIDTH-1:0] io_rule_bits_0,
  input  logic [WIDTH-1:0] io_rule_bits_1,
  input  logic [WIDTH-1:0] io_rule_bits_2,
  input  logic [WIDTH-1:0] io_rule_bits_3,
  output logic             io_cmp_start,
  output logic [WIDTH-1:0] io_cmp_inputs_0,
  output logic [WIDTH-1:0] io_cmp_inputs_1,
  output logic [WIDTH-1:0] io_cmp_inputs_2,
  output logic [WIDTH-1:0] io_cmp_inputs_3,
  input  logic [WIDTH-1:0] io_cmp_result,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  output logic             io_busy
);

  localparam int CNT_W = $clog2(MAX_RULES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] numRules;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] retired;
  logic [WIDTH-1:0] acc;
  logic             tag0;
  logic             tag1;

  logic cmdFire;
  logic ruleFire;
  logic retire;
  logic lastIssue;
  logic lastRetire;

  assign cmdFire    = io_cmd_valid & io_cmd_ready;
  assign ruleFire   = io_rule_valid & io_rule_ready;
  // tag1 only ever holds a 1 while the tree is advancing, but gating keeps a
  // frozen tree from ever retiring.
  assign retire     = tag1 & io_cmp_start;
  assign lastIssue  = ruleFire && ((issued + CNT_W'(1)) == numRules);
  assign lastRetire = retire && ((retired + CNT_W'(1)) == numRules);

  assign io_cmp_inputs_0 = io_rule_bits_0;
  assign io_cmp_inputs_1 = io_rule_bits_1;
  assign io_cmp_inputs_2 = io_rule_bits_2;
  assign io_cmp_inputs_3 = io_rule_bits_3;
  assign io_out_bits     = acc;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (io_cmd_valid) begin
          stateNext = (io_cmd_bits_numRules == 4'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (lastRetire)     stateNext = DONE;
        else if (lastIssue) stateNext = DRAIN;
      end
      DRAIN: begin
        if (lastRetire) stateNext = DONE;
      end
      DONE: begin
        if (io_out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Handshake and tree-enable outputs decoded from state
  always_comb begin
    io_cmd_ready  = (state == IDLE);
    io_rule_ready = (state == ISSUE);
    io_cmp_start  = (state == ISSUE) || (state == DRAIN);
    io_out_valid  = (state == DONE);
    io_busy       = (state != IDLE);
  end

  // Counters, slot tags and max-accumulator
  always_ff @(posedge clock) begin
    if (reset) begin
      numRules <= '0;
      issued   <= '0;
      retired  <= '0;
      acc      <= '0;
      tag0     <= 1'b0;
      tag1     <= 1'b0;
    end else begin
      if (cmdFire) begin
        numRules <= CNT_W'(io_cmd_bits_numRules);
        issued   <= '0;
        retired  <= '0;
        acc      <= '0;
      end
      if (ruleFire) begin
        issued <= issued + CNT_W'(1);
      end
      if (io_cmp_start) begin
        tag0 <= ruleFire;
        tag1 <= tag0;
      end
      if (retire) begin
        if (io_cmp_result > acc) acc <= io_cmp_result;
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fuzzy_rule_scheduler.sv
// Self-checking bench for fuzzy_rule_scheduler. Provides a min-mode two-stage
// comparator tree as environment and checks results against a max-of-min
// reference computed directly from the rule table.
module tb_fuzzy_rule_scheduler;

  localparam int W = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         io_cmd_valid;
  logic         io_cmd_ready;
  logic [3:0]   io_cmd_bits_numRules;
  logic         io_rule_valid;
  logic         io_rule_ready;
  logic [W-1:0] io_rule_bits_0, io_rule_bits_1, io_rule_bits_2, io_rule_bits_3;
  logic         io_cmp_start;
  logic [W-1:0] io_cmp_inputs_0, io_cmp_inputs_1, io_cmp_inputs_2, io_cmp_inputs_3;
  logic [W-1:0] io_cmp_result;
  logic         io_out_valid;
  logic         io_out_ready;
  logic [W-1:0] io_out_bits;
  logic         io_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] ruleMem [16][4];

  int           obsFires, obsFirst, obsOutCyc, obsCmdCyc, obsExtraReady;
  bit           obsStartSeen, obsTimeout;
  logic [W-1:0] obsOut;

  logic [W-1:0] treeS1 = '0;
  logic [W-1:0] treeS2 = '0;

  fuzzy_rule_scheduler #(.WIDTH(W), .MAX_RULES(15)) dut (
    .clock                (clock),
    .reset                (reset),
    .io_cmd_valid         (io_cmd_valid),
    .io_cmd_ready         (io_cmd_ready),
    .io_cmd_bits_numRules (io_cmd_bits_numRules),
    .io_rule_valid        (io_rule_valid),
    .io_rule_ready        (io_rule_ready),
    .io_rule_bits_0       (io_rule_bits_0),
    .io_rule_bits_1       (io_rule_bits_1),
    .io_rule_bits_2       (io_rule_bits_2),
    .io_rule_bits_3       (io_rule_bits_3),
    .io_cmp_start         (io_cmp_start),
    .io_cmp_inputs_0      (io_cmp_inputs_0),
    .io_cmp_inputs_1      (io_cmp_inputs_1),
    .io_cmp_inputs_2      (io_cmp_inputs_2),
    .io_cmp_inputs_3      (io_cmp_inputs_3),
    .io_cmp_result        (io_cmp_result),
    .io_out_valid         (io_out_valid),
    .io_out_ready         (io_out_ready),
    .io_out_bits          (io_out_bits),
    .io_busy              (io_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [W-1:0] min4(input logic [W-1:0] a, b, c, d);
    logic [W-1:0] m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    if (d < m) m = d;
    return m;
  endfunction

  // Comparator tree environment: min of four, two enabled stages deep
  always @(posedge clock) begin
    if (io_cmp_start) begin
      treeS1 <= min4(io_cmp_inputs_0, io_cmp_inputs_1, io_cmp_inputs_2, io_cmp_inputs_3);
      treeS2 <= treeS1;
    end
  end
  assign io_cmp_result = treeS2;

  // Reference: strongest rule = max over rules of min over its memberships
  function automatic int ref_strength(input int n);
    int best;
    int m;
    best = 0;
    for (int i = 0; i < n; i++) begin
      m = 7;
      for (int k = 0; k < 4; k++) if (int'(ruleMem[i][k]) < m) m = int'(ruleMem[i][k]);
      if (m > best) best = m;
    end
    return best;
  endfunction

  task automatic load_rule(input int i, input int a, input int b, input int c, input int d);
    ruleMem[i][0] = W'(a);
    ruleMem[i][1] = W'(b);
    ruleMem[i][2] = W'(c);
    ruleMem[i][3] = W'(d);
  endtask

  task automatic randomize_rules();
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 4; k++) ruleMem[i][k] = W'($urandom_range(7));
  endtask

  task automatic drive_bits(input int idx, input bit junkHigh);
    if (idx >= 0) begin
      io_rule_bits_0 = ruleMem[idx][0];
      io_rule_bits_1 = ruleMem[idx][1];
      io_rule_bits_2 = ruleMem[idx][2];
      io_rule_bits_3 = ruleMem[idx][3];
    end else if (junkHigh) begin
      io_rule_bits_0 = '1;
      io_rule_bits_1 = '1;
      io_rule_bits_2 = '1;
      io_rule_bits_3 = '1;
    end else begin
      io_rule_bits_0 = W'($urandom_range(7));
      io_rule_bits_1 = W'($urandom_range(7));
      io_rule_bits_2 = W'($urandom_range(7));
      io_rule_bits_3 = W'($urandom_range(7));
    end
  endtask

  // Issue one command and feed rules; mode 0 back-to-back, 1 alternate
  // bubbles (bubble operands all-ones), 2 random bubbles. Returns at the
  // first negedge with io_out_valid high (or on budget expiry).
  task automatic drive_cmd(input int n, input int mode);
    int  idx;
    int  budget;
    bit  toggle;
    bit  offer;
    obsFires = 0; obsFirst = -1; obsOutCyc = -1; obsExtraReady = 0;
    obsStartSeen = 0; obsTimeout = 0;
    @(negedge clock);
    io_cmd_valid = 1'b1;
    io_cmd_bits_numRules = 4'(n);
    obsCmdCyc = cyc;
    @(negedge clock);
    io_cmd_valid = 1'b0;
    io_cmd_bits_numRules = 4'($urandom_range(15));
    idx = 0; budget = 0; toggle = 1'b1;
    while (!io_out_valid && budget < 100) begin
      if (io_cmp_start) obsStartSeen = 1'b1;
      offer = 1'b0;
      if (io_rule_ready && idx < n) begin
        case (mode)
          0:       offer = 1'b1;
          1:       offer = toggle;
          default: offer = ($urandom_range(3) != 0);
        endcase
        toggle = !toggle;
      end else if (io_rule_ready) begin
        obsExtraReady++;
      end
      if (offer) begin
        io_rule_valid = 1'b1;
        drive_bits(idx, 1'b0);
        if (obsFirst < 0) obsFirst = cyc;
        obsFires++;
        idx++;
      end else begin
        io_rule_valid = io_rule_ready ? 1'b0 : 1'($urandom_range(1));
        drive_bits(-1, mode == 1);
      end
      @(negedge clock);
      budget++;
    end
    io_rule_valid = 1'b0;
    obsTimeout = !io_out_valid;
    obsOutCyc  = cyc;
    obsOut     = io_out_bits;
  endtask

  task automatic release_out(input int hold);
    repeat (hold) @(negedge clock);
    io_out_ready = 1'b1;
    @(negedge clock);
    io_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (io_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b expected 1", io_cmd_ready); end
    checks++; if (io_rule_ready !== 1'b0) begin errors++; $display("FAIL reset_rule_ready: got %0b expected 0", io_rule_ready); end
    checks++; if (io_cmp_start !== 1'b0) begin errors++; $display("FAIL reset_cmp_start: got %0b expected 0", io_cmp_start); end
    checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", io_out_valid); end
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", io_busy); end
    checks++; if (io_out_bits !== 3'd0) begin errors++; $display("FAIL reset_out_bits: got %0d expected 0", io_out_bits); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (io_cmd_ready !== 1'b1 || io_busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got ready=%0b busy=%0b expected 1/0", io_cmd_ready, io_busy);
    end
  endtask

  task automatic test_directed_min();
    load_rule(0, 3, 5, 6, 7);
    load_rule(1, 1, 2, 2, 4);
    load_rule(2, 6, 6, 7, 6);
    load_rule(3, 0, 7, 7, 7);
    drive_cmd(4, 0);
    checks++; if (obsTimeout !== 1'b0) begin errors++; $display("FAIL directed_timeout: got timeout expected out_valid"); end
    checks++; if (obsOutCyc - obsFirst !== 6) begin errors++; $display("FAIL directed_latency: got %0d expected 6", obsOutCyc - obsFirst); end
    checks++; if (obsOut !== 3'd6) begin errors++; $display("FAIL directed_out_bits: got %0d expected 6", obsOut); end
    checks++; if (obsFires !== 4) begin errors++; $display("FAIL directed_fires: got %0d expected 4", obsFires); end
    checks++; if (io_cmp_start !== 1'b0) begin errors++; $display("FAIL directed_done_cmp_start: got %0b expected 0", io_cmp_start); end
    release_out(0);
  endtask

  task automatic test_zero_rules();
    drive_cmd(0, 0);
    checks++; if (obsOutCyc - obsCmdCyc !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", obsOutCyc - obsCmdCyc); end
    checks++; if (obsOut !== 3'd0) begin errors++; $display("FAIL zero_out_bits: got %0d expected 0", obsOut); end
    checks++; if (obsFires !== 0 || obsExtraReady !== 0) begin
      errors++; $display("FAIL zero_rules_accepted: got fires=%0d ready=%0d expected 0/0", obsFires, obsExtraReady);
    end
    checks++; if (obsStartSeen !== 1'b0 || io_cmp_start !== 1'b0) begin
      errors++; $display("FAIL zero_cmp_start: got seen=%0b expected 0", obsStartSeen);
    end
    release_out(0);
  endtask

  task automatic test_bubbles();
    randomize_rules();
    drive_cmd(3, 1);
    checks++; if (obsTimeout !== 1'b0) begin errors++; $display("FAIL bubbles_timeout: got timeout expected out_valid"); end
    checks++; if (int'(obsOut) !== ref_strength(3)) begin errors++; $display("FAIL bubbles_out_bits: got %0d expected %0d", obsOut, ref_strength(3)); end
    checks++; if (obsFires !== 3 || obsExtraReady !== 0) begin
      errors++; $display("FAIL bubbles_fires: got %0d extra=%0d expected 3/0", obsFires, obsExtraReady);
    end
    checks++; if (obsOutCyc - obsFirst !== 7) begin errors++; $display("FAIL bubbles_latency: got %0d expected 7", obsOutCyc - obsFirst); end
    release_out(0);
  endtask

  task automatic test_hold_output();
    logic [W-1:0] held;
    randomize_rules();
    drive_cmd(5, 0);
    held = 3'(ref_strength(5));
    checks++; if (obsOut !== held) begin errors++; $display("FAIL hold_out_bits: got %0d expected %0d", obsOut, held); end
    io_cmd_valid = 1'b1;
    io_cmd_bits_numRules = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (io_out_valid !== 1'b1 || io_out_bits !== held) begin
        errors++; $display("FAIL hold_stable: got valid=%0b bits=%0d expected 1/%0d", io_out_valid, io_out_bits, held);
      end
      checks++; if (io_cmd_ready !== 1'b0 || io_busy !== 1'b1) begin
        errors++; $display("FAIL hold_cmd_ready: got ready=%0b busy=%0b expected 0/1", io_cmd_ready, io_busy);
      end
    end
    io_cmd_valid = 1'b0;
    io_out_ready = 1'b1;
    @(negedge clock);
    io_out_ready = 1'b0;
    checks++; if (io_cmd_ready !== 1'b1 || io_busy !== 1'b0 || io_out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release_idle: got ready=%0b busy=%0b valid=%0b expected 1/0/0", io_cmd_ready, io_busy, io_out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    randomize_rules();
    @(negedge clock);
    io_cmd_valid = 1'b1;
    io_cmd_bits_numRules = 4'd4;
    @(negedge clock);
    io_cmd_valid = 1'b0;
    io_rule_valid = 1'b1;
    drive_bits(0, 1'b0);
    @(negedge clock);
    drive_bits(1, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    drive_bits(2, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    io_rule_valid = 1'b0;
    checks++; if (io_busy !== 1'b0 || io_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL abort_idle: got busy=%0b ready=%0b expected 0/1", io_busy, io_cmd_ready);
    end
    pulses = 0;
    repeat (6) begin
      if (io_out_valid || io_cmp_start) pulses++;
      @(negedge clock);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_pulse: got %0d active cycles expected 0", pulses); end
    load_rule(0, 7, 7, 7, 7);
    drive_cmd(1, 0);
    checks++; if (obsOut !== 3'd7 || obsTimeout !== 1'b0) begin
      errors++; $display("FAIL abort_fresh_cmd: got %0d timeout=%0b expected 7/0", obsOut, obsTimeout);
    end
    checks++; if (obsOutCyc - obsFirst !== 3) begin errors++; $display("FAIL abort_fresh_latency: got %0d expected 3", obsOutCyc - obsFirst); end
    release_out(0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 15; i++) load_rule(i, 7, 7, 7, 7);
    drive_cmd(15, 0);
    checks++; if (obsOut !== 3'd7) begin errors++; $display("FAIL sat_out_bits: got %0d expected 7", obsOut); end
    checks++; if (obsFires !== 15 || obsExtraReady !== 0) begin
      errors++; $display("FAIL sat_fires: got %0d extra=%0d expected 15/0", obsFires, obsExtraReady);
    end
    checks++; if (obsOutCyc - obsFirst !== 17) begin errors++; $display("FAIL sat_latency: got %0d expected 17", obsOutCyc - obsFirst); end
    release_out(1);
  endtask

  task automatic test_back_to_back();
    int n;
    int mode;
    for (int it = 0; it < 30; it++) begin
      randomize_rules();
      n = $urandom_range(15);
      mode = $urandom_range(2);
      drive_cmd(n, mode);
      checks++; if (obsTimeout !== 1'b0) begin errors++; $display("FAIL b2b_timeout[%0d]: got timeout expected out_valid", it); end
      checks++; if (int'(obsOut) !== ref_strength(n)) begin
        errors++; $display("FAIL b2b_out_bits[%0d]: got %0d expected %0d (n=%0d mode=%0d)", it, obsOut, ref_strength(n), n, mode);
      end
      checks++; if (obsFires !== n || obsExtraReady !== 0) begin
        errors++; $display("FAIL b2b_fires[%0d]: got %0d extra=%0d expected %0d/0", it, obsFires, obsExtraReady, n);
      end
      if (mode == 0 && n > 0) begin
        checks++; if (obsOutCyc - obsFirst !== n + 2) begin
          errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", it, obsOutCyc - obsFirst, n + 2);
        end
      end
      release_out($urandom_range(2));
    end
  endtask

  initial begin
    reset = 1'b1;
    io_cmd_valid = 1'b0;
    io_cmd_bits_numRules = '0;
    io_rule_valid = 1'b0;
    io_rule_bits_0 = '0;
    io_rule_bits_1 = '0;
    io_rule_bits_2 = '0;
    io_rule_bits_3 = '0;
    io_out_ready = 1'b0;
    test_reset();
    test_directed_min();
    test_zero_rules();
    test_bubbles();
    test_hold_output();
    test_reset_abort();
    test_saturation();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
